// File: rtl/dm_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// State encodings, requester IDs and the round-robin successor helper.
package dm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    FILL  = 2'd3
  } dm_state_e;

  localparam logic [1:0] REQ_LD   = 2'd0;
  localparam logic [1:0] REQ_ST   = 2'd1;
  localparam logic [1:0] REQ_FILL = 2'd2;

  localparam int WORD_W = 32;
  localparam int LINE_W = 256;

  // Requester that gets first look after the given winner.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    logic [1:0] nxt;
    case (id)
      REQ_LD:  nxt = REQ_ST;
      REQ_ST:  nxt = REQ_FILL;
      default: nxt = REQ_LD;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/dm_rr_arbiter.sv
// Three-way round-robin arbiter: search starts at ptr and goes LD -> ST -> FILL.
// Purely combinational; gnt is one-hot or zero.
module dm_rr_arbiter
  import dm_ctrl_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  // Priority search rotated to begin at the pointer.
  always_comb begin
    gnt = 3'b000;
    case (ptr)
      REQ_ST: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else             gnt = 3'b000;
      end
      REQ_FILL: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else             gnt = 3'b000;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else             gnt = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequences load, store-commit and line-fill accesses onto the single-ported
// data memory, holding each word access for MEM_LAT cycles.
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int LINE_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req,
  input  logic [31:0]       ld_addr,
  output logic              ld_gnt,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  input  logic              st_req,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  output logic              st_gnt,
  output logic              st_done,
  input  logic              fill_req,
  input  logic [31:0]       fill_addr,
  output logic              fill_gnt,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_line,
  output logic [31:0]       dm_ld_addr,
  input  logic [31:0]       dm_ld_data,
  output logic [31:0]       dm_st_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_we
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int WIX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MEM_LAT - 1);
  localparam logic [WIX_W-1:0] WIX_LAST  = WIX_W'(LINE_WORDS - 1);
  localparam logic [31:0]      LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);

  dm_state_e         state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIX_W-1:0]  word_q, word_d;
  logic [LINE_W-1:0] line_buf_q, line_buf_d, line_nxt;
  logic [LINE_W-1:0] fill_line_q, fill_line_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d;
  logic              st_done_q, st_done_d;
  logic              fill_valid_q, fill_valid_d;
  logic [31:0]       dm_ld_addr_q, dm_ld_addr_d;
  logic [31:0]       dm_st_addr_q, dm_st_addr_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d;
  logic              dm_we_q, dm_we_d;
  logic [2:0]        arb_gnt_s, gnt_s;

  dm_rr_arbiter u_arb (
    .req ({fill_req, st_req, ld_req}),
    .ptr (ptr_q),
    .gnt (arb_gnt_s)
  );

  // Grants are only offered while no transaction is in flight.
  always_comb begin
    if (state_q == IDLE) gnt_s = arb_gnt_s;
    else                 gnt_s = 3'b000;
  end

  // Next-state and datapath updates for the access sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    line_buf_d   = line_buf_q;
    line_nxt     = line_buf_q;
    fill_line_d  = fill_line_q;
    ld_data_d    = ld_data_q;
    ld_valid_d   = 1'b0;
    st_done_d    = 1'b0;
    fill_valid_d = 1'b0;
    dm_ld_addr_d = dm_ld_addr_q;
    dm_st_addr_d = dm_st_addr_q;
    dm_wdata_d   = dm_wdata_q;
    dm_we_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_s[0]) begin
          state_d      = LOAD;
          cnt_d        = CNT_LOAD;
          ptr_d        = rr_next(REQ_LD);
          dm_ld_addr_d = {ld_addr[31:2], 2'b00};
        end else if (gnt_s[1]) begin
          state_d      = STORE;
          cnt_d        = CNT_LOAD;
          ptr_d        = rr_next(REQ_ST);
          dm_st_addr_d = {st_addr[31:2], 2'b00};
          dm_wdata_d   = st_data;
          dm_we_d      = 1'b1;
        end else if (gnt_s[2]) begin
          state_d      = FILL;
          cnt_d        = CNT_LOAD;
          ptr_d        = rr_next(REQ_FILL);
          word_d       = '0;
          dm_ld_addr_d = fill_addr & LINE_MASK;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          ld_data_d  = dm_ld_data;
          ld_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STORE: begin
        if (cnt_q == '0) begin
          st_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FILL: begin
        if (cnt_q == '0) begin
          // Words collect in a staging buffer so fill_line only moves on completion.
          line_nxt[word_q*WORD_W +: WORD_W] = dm_ld_data;
          line_buf_d = line_nxt;
          if (word_q == WIX_LAST) begin
            fill_line_d  = line_nxt;
            fill_valid_d = 1'b1;
            word_d       = '0;
            cnt_d        = '0;
            state_d      = IDLE;
          end else begin
            word_d       = word_q + 1'b1;
            cnt_d        = CNT_LOAD;
            dm_ld_addr_d = dm_ld_addr_q + 32'd4;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= REQ_LD;
      cnt_q        <= '0;
      word_q       <= '0;
      line_buf_q   <= '0;
      fill_line_q  <= '0;
      ld_data_q    <= 32'd0;
      ld_valid_q   <= 1'b0;
      st_done_q    <= 1'b0;
      fill_valid_q <= 1'b0;
      dm_ld_addr_q <= 32'd0;
      dm_st_addr_q <= 32'd0;
      dm_wdata_q   <= 32'd0;
      dm_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      line_buf_q   <= line_buf_d;
      fill_line_q  <= fill_line_d;
      ld_data_q    <= ld_data_d;
      ld_valid_q   <= ld_valid_d;
      st_done_q    <= st_done_d;
      fill_valid_q <= fill_valid_d;
      dm_ld_addr_q <= dm_ld_addr_d;
      dm_st_addr_q <= dm_st_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      dm_we_q      <= dm_we_d;
    end
  end

  assign ld_gnt     = gnt_s[0];
  assign st_gnt     = gnt_s[1];
  assign fill_gnt   = gnt_s[2];
  assign ld_valid   = ld_valid_q;
  assign ld_data    = ld_data_q;
  assign st_done    = st_done_q;
  assign fill_valid = fill_valid_q;
  assign fill_line  = fill_line_q;
  assign dm_ld_addr = dm_ld_addr_q;
  assign dm_st_addr = dm_st_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_we      = dm_we_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a MEM_LAT=2 instance driven from a vector
// table plus corner sequences, and a MEM_LAT=1 instance for back-to-back stores.
module tb_dm_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance
  logic ld_req0 = 1'b0, st_req0 = 1'b0, fill_req0 = 1'b0;
  logic [31:0] ld_addr0 = 32'd0, st_addr0 = 32'd0, st_data0 = 32'd0, fill_addr0 = 32'd0;
  logic ld_gnt0, ld_valid0, st_gnt0, st_done0, fill_gnt0, fill_valid0, dm_we0;
  logic [31:0] ld_data0, dm_ld_addr0, dm_ld_data0, dm_st_addr0, dm_wdata0;
  logic [255:0] fill_line0;

  // MEM_LAT=1 instance
  logic ld_req1 = 1'b0, st_req1 = 1'b0, fill_req1 = 1'b0;
  logic [31:0] ld_addr1 = 32'd0, st_addr1 = 32'd0, st_data1 = 32'd0, fill_addr1 = 32'd0;
  logic ld_gnt1, ld_valid1, st_gnt1, st_done1, fill_gnt1, fill_valid1, dm_we1;
  logic [31:0] ld_data1, dm_ld_addr1, dm_ld_data1, dm_st_addr1, dm_wdata1;
  logic [255:0] fill_line1;

  dm_access_ctrl #(.MEM_LAT(2), .LINE_WORDS(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req0), .ld_addr(ld_addr0), .ld_gnt(ld_gnt0), .ld_valid(ld_valid0), .ld_data(ld_data0),
    .st_req(st_req0), .st_addr(st_addr0), .st_data(st_data0), .st_gnt(st_gnt0), .st_done(st_done0),
    .fill_req(fill_req0), .fill_addr(fill_addr0), .fill_gnt(fill_gnt0), .fill_valid(fill_valid0),
    .fill_line(fill_line0), .dm_ld_addr(dm_ld_addr0), .dm_ld_data(dm_ld_data0),
    .dm_st_addr(dm_st_addr0), .dm_wdata(dm_wdata0), .dm_we(dm_we0)
  );

  dm_access_ctrl #(.MEM_LAT(1), .LINE_WORDS(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ld_req(ld_req1), .ld_addr(ld_addr1), .ld_gnt(ld_gnt1), .ld_valid(ld_valid1), .ld_data(ld_data1),
    .st_req(st_req1), .st_addr(st_addr1), .st_data(st_data1), .st_gnt(st_gnt1), .st_done(st_done1),
    .fill_req(fill_req1), .fill_addr(fill_addr1), .fill_gnt(fill_gnt1), .fill_valid(fill_valid1),
    .fill_line(fill_line1), .dm_ld_addr(dm_ld_addr1), .dm_ld_data(dm_ld_data1),
    .dm_st_addr(dm_st_addr1), .dm_wdata(dm_wdata1), .dm_we(dm_we1)
  );

  // Memory models: combinational read, write on the clock edge while dm_we is high.
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:15];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_val = 32'd0;
  int wr_cnt0 = 0, wr_cnt1 = 0, fv_cnt = 0;

  assign dm_ld_data0 = mem0[dm_ld_addr0[9:2]];
  assign dm_ld_data1 = mem1[dm_ld_addr1[5:2]];

  always @(posedge clk) begin
    if (pl_en) mem0[pl_idx] <= pl_val;
    else if (dm_we0) mem0[dm_st_addr0[9:2]] <= dm_wdata0;
  end
  always @(posedge clk) begin
    if (dm_we0) wr_cnt0 <= wr_cnt0 + 1;
    if (fill_valid0) fv_cnt <= fv_cnt + 1;
  end
  always @(posedge clk) begin
    if (dm_we1) begin
      mem1[dm_st_addr1[5:2]] <= dm_wdata1;
      wr_cnt1 <= wr_cnt1 + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          op;        // 0 load, 1 store, 2 fill
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_word;
    logic [31:0] exp_dm_addr;
    logic [255:0] exp_line;
    int          exp_lat;
  } vec_t;

  vec_t vt [8];

  task automatic run_txn(input vec_t v, input int idx);
    logic [2:0] exp_g;
    int lat;
    int w0;
    logic vld;
    exp_g = (v.op == 0) ? 3'b100 : ((v.op == 1) ? 3'b010 : 3'b001);
    @(negedge clk);
    case (v.op)
      0: begin ld_req0 = 1'b1; ld_addr0 = v.addr; end
      1: begin st_req0 = 1'b1; st_addr0 = v.addr; st_data0 = v.data; end
      default: begin fill_req0 = 1'b1; fill_addr0 = v.addr; end
    endcase
    #1;
    chk($sformatf("v%0d_gnt", idx), {ld_gnt0, st_gnt0, fill_gnt0}, exp_g);
    w0 = wr_cnt0;
    @(posedge clk);
    #1;
    ld_req0 = 1'b0; st_req0 = 1'b0; fill_req0 = 1'b0;
    if (v.op == 1) chk($sformatf("v%0d_wr", idx), {dm_we0, dm_st_addr0, dm_wdata0}, {1'b1, v.exp_dm_addr, v.data});
    else           chk($sformatf("v%0d_rdaddr", idx), dm_ld_addr0, v.exp_dm_addr);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (v.op == 1 && k == 1) chk($sformatf("v%0d_we_once", idx), dm_we0, 1'b0);
      if (v.op == 2 && k == 14) chk($sformatf("v%0d_lastaddr", idx), dm_ld_addr0, v.exp_dm_addr + 32'd28);
      vld = (v.op == 0) ? ld_valid0 : ((v.op == 1) ? st_done0 : fill_valid0);
      if (vld) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.exp_lat));
    case (v.op)
      0: chk($sformatf("v%0d_ld_data", idx), ld_data0, v.exp_word);
      1: chk($sformatf("v%0d_mem", idx), {32'(wr_cnt0 - w0), mem0[v.exp_dm_addr[9:2]]}, {32'd1, v.data});
      default: chk($sformatf("v%0d_line", idx), fill_line0, v.exp_line);
    endcase
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_pulse", idx), {ld_valid0, st_done0, fill_valid0}, 3'b000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [255:0] line1, line2;
  logic [11:0] order;
  int n_g, multi, fv0;
  logic [2:0] g;

  initial begin
    line1 = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
    line2 = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hCAFEF00D};
    vt[0] = '{0, 32'h40,  32'h0,        32'hDEADBEEF, 32'h40,  256'h0, 2};
    vt[1] = '{1, 32'h47,  32'h12345678, 32'h0,        32'h44,  256'h0, 2};
    vt[2] = '{0, 32'h44,  32'h0,        32'h12345678, 32'h44,  256'h0, 2};
    vt[3] = '{2, 32'h10F, 32'h0,        32'h0,        32'h100, line1,  16};
    vt[4] = '{0, 32'h102, 32'h0,        32'hA0,       32'h100, 256'h0, 2};
    vt[5] = '{1, 32'h103, 32'hCAFEF00D, 32'h0,        32'h100, 256'h0, 2};
    vt[6] = '{0, 32'h100, 32'h0,        32'hCAFEF00D, 32'h100, 256'h0, 2};
    vt[7] = '{2, 32'h11C, 32'h0,        32'h0,        32'h100, line2,  16};

    // Preload memory while reset is held.
    rst_n = 1'b0;
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 8'h10; pl_val = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pl_idx = 8'h40 + 8'(i);
      pl_val = 32'hA0 + 32'(i);
    end
    @(negedge clk);
    pl_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ctl", {ld_valid0, st_done0, fill_valid0, dm_we0, ld_gnt0, st_gnt0, fill_gnt0}, 7'd0);
    chk("rst_data", {ld_data0, dm_ld_addr0, dm_st_addr0, dm_wdata0}, 128'd0);
    chk("rst_line", fill_line0, 256'd0);

    for (int i = 0; i < 8; i++) run_txn(vt[i], i);

    // All three requesters held: grants must rotate LD, ST, FILL.
    do_reset();
    @(negedge clk);
    ld_req0 = 1'b1; ld_addr0 = 32'h40;
    st_req0 = 1'b1; st_addr0 = 32'h80; st_data0 = 32'h5;
    fill_req0 = 1'b1; fill_addr0 = 32'h100;
    n_g = 0; multi = 0; order = 12'd0;
    for (int c = 0; c < 300 && n_g < 6; c++) begin
      #1;
      g = {fill_gnt0, st_gnt0, ld_gnt0};
      if ($countones(g) > 1) multi++;
      if (g != 3'b000) begin
        order = {order[9:0], (g[0] ? 2'd0 : (g[1] ? 2'd1 : 2'd2))};
        n_g++;
      end
      @(negedge clk);
    end
    ld_req0 = 1'b0; st_req0 = 1'b0; fill_req0 = 1'b0;
    chk("rr_order", {32'(n_g), order}, {32'd6, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2});
    chk("rr_onehot", 32'(multi), 32'd0);
    repeat (40) @(posedge clk);

    // Reset five cycles into a fill aborts it; the fill is then re-served from word 0.
    do_reset();
    @(negedge clk);
    fill_req0 = 1'b1; fill_addr0 = 32'h100;
    @(posedge clk);
    #1;
    fill_req0 = 1'b0;
    fv0 = fv_cnt;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {fill_valid0, dm_we0, ld_valid0, st_done0}, 4'd0);
    chk("abort_data", {ld_data0, dm_ld_addr0, dm_st_addr0, dm_wdata0}, 128'd0);
    chk("abort_line", fill_line0, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_nofv", 32'(fv_cnt - fv0), 32'd0);
    run_txn(vt[7], 8);

    // MEM_LAT=1: back-to-back stores, one IDLE cycle between them.
    @(negedge clk);
    st_req1 = 1'b1; st_addr1 = 32'h0; st_data1 = 32'h11111111;
    #1;
    chk("b2b_gnt0", st_gnt1, 1'b1);
    @(posedge clk);
    #1;
    st_addr1 = 32'h4; st_data1 = 32'h22222222;
    chk("b2b_wr0", {dm_we1, st_done1, st_gnt1, dm_st_addr1}, {3'b100, 32'h0});
    @(posedge clk);
    #1;
    chk("b2b_done0", {dm_we1, st_done1, st_gnt1}, 3'b011);
    @(posedge clk);
    #1;
    st_req1 = 1'b0;
    chk("b2b_wr1", {dm_we1, st_done1, dm_st_addr1}, {2'b10, 32'h4});
    @(posedge clk);
    #1;
    chk("b2b_done1", {dm_we1, st_done1}, 2'b01);
    @(posedge clk);
    #1;
    chk("b2b_mem", {32'(wr_cnt1), mem1[0], mem1[1], 1'b0, st_done1}, {32'd2, 32'h11111111, 32'h22222222, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Sequencing controller for the single-ported data memory. It shares the memory between three requesters: the load path (ROB), the store-commit path, and the cache line-fill path. It drives the memory's load address, store address, write enable and write data, and holds each access for a fixed latency. It returns word or 256-bit line results with valid/done pulses, and sits between the load/store units, the cache and the data memory.

## Interface
Parameters:
- MEM_LAT, 2: cycles each memory word access is held (≥1)
- LINE_WORDS, 8: 32-bit words per cache line (line = 256 bits, 32-byte aligned)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  async active-low reset
- ld_req  in  1  load request; held with ld_addr until ld_gnt
- ld_addr  in  32  load byte address
- ld_gnt  out  1  load accepted this cycle
- ld_valid  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  loaded word (registered)
- st_req  in  1  store request; held with st_addr/st_data until st_gnt
- st_addr  in  32  store byte address
- st_data  in  32  store word
- st_gnt  out  1  store accepted this cycle
- st_done  out  1  one-cycle pulse, store committed
- fill_req  in  1  line-fill request; held with fill_addr until fill_gnt
- fill_addr  in  32  line address, bits [4:0] ignored
- fill_gnt  out  1  fill accepted this cycle
- fill_valid  out  1  one-cycle pulse, fill_line valid
- fill_line  out  256  word w in bits [32w+31:32w]
- dm_ld_addr  out  32  memory read address, bits [1:0]=0
- dm_ld_data  in  32  memory read data (valid while dm_ld_addr stable)
- dm_st_addr  out  32  memory write address, bits [1:0]=0
- dm_wdata  out  32  memory write data
- dm_we  out  1  memory write enable

## Operation
- FSM states: IDLE, LOAD, STORE, FILL.
- Grant logic:
  - In IDLE, grants are combinational from the requests and the round-robin pointer. The order is LD→ST→FILL, starting at the pointer.
  - At most one gnt is high at a time, and only in IDLE.
  - Handshake occurs at the edge where req&&gnt. At that edge: latch addr/data, load the beat counter with MEM_LAT-1, enter the target state, and set the pointer to the requester after the winner.
- LOAD:
  - Drive dm_ld_addr = {addr[31:2],2'b00} for MEM_LAT cycles.
  - At the edge where the counter reaches 0: ld_data<=dm_ld_data, ld_valid<=1, return to IDLE.
- STORE:
  - Drive dm_st_addr/dm_wdata for MEM_LAT cycles.
  - dm_we is high only in the first STORE cycle, so there is exactly one write per store.
  - At the final edge: st_done<=1, return to IDLE.
- FILL:
  - A 3-bit word counter w runs from 0 to 7. dm_ld_addr = {base[31:5], w, 2'b00}, each word held MEM_LAT cycles.
  - At each word's final edge, capture dm_ld_data into slice w.
  - After w=7: fill_valid<=1, return to IDLE. w wraps to 0.
- fill_line and ld_data hold their last value until the next completion.
- Requests that are not granted wait; no request is ever dropped.
- Simultaneous requests are served in pointer order, so no requester waits more than two other transactions.
- Outside the active state, dm_ld_addr and dm_st_addr hold their last values and dm_we=0.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, pointer=LD, counters=0.
  - ld_valid, st_done, fill_valid, dm_we = 0.
  - ld_data, fill_line, dm_* addresses, dm_wdata = 0.
- Reset mid-transaction aborts it: no valid/done pulse, and dm_we drops immediately.
- Latency from the handshake edge E0:
  - ld_valid at E0+MEM_LAT.
  - st_done at E0+MEM_LAT, with the write occurring at edge E0+1.
  - fill_valid at E0+LINE_WORDS·MEM_LAT.
- Back-to-back: the cycle after a completion edge is IDLE, and a new grant is possible in it. Throughput is one word access per MEM_LAT cycles plus one IDLE cycle per transaction.
- Valid/done pulses last exactly one cycle.

## Structure
- Shared package/include dm_ctrl_pkg:
  - state encodings IDLE=2'd0, LOAD=2'd1, STORE=2'd2, FILL=2'd3
  - requester IDs REQ_LD=0, REQ_ST=1, REQ_FILL=2
  - WORD_W=32, LINE_W=256
- Sub-module dm_rr_arbiter: 3-way round-robin, with req[2:0] and ptr in, and one-hot gnt out.

## Test plan
- Reset then ld_req, addr 0x40 with mem[0x10]=0xDEADBEEF (MEM_LAT=2) → ld_gnt at cycle 0, ld_valid with ld_data=0xDEADBEEF exactly 2 edges later, dm_ld_addr=0x40.
- st_req addr 0x47, data 0x12345678 → dm_we high for exactly one cycle with dm_st_addr=0x44, st_done 2 edges after handshake; a following load of 0x44 returns 0x12345678.
- fill_req addr 0x10F with mem words 0x40..0x47 = 0xA0..0xA7 → 8 reads at 0x100..0x11C, fill_valid 16 edges after handshake, fill_line[31:0]=0xA0 and [255:224]=0xA7.
- ld_req, st_req and fill_req all held continuously from reset → grant order LD, ST, FILL, LD, ST, …; never two gnts high together.
- rst_n asserted 5 cycles into a fill → no fill_valid, all outputs zero at once, and the fill is re-served from word 0 after release.
- MEM_LAT=1 build: back-to-back stores to 0x0, 0x4 → st_done on consecutive handshakes separated by one IDLE cycle, and each word written once.
